fp_add_arbiter: RTL
===================

# fp_add_arbiter

Shares one floating-point adder between up to `NUM_REQ` sequencing sub-blocks, such as angle combination, angle normalization and term accumulation, so they can run concurrently without a per-state operand mux. Each requester issues a one-cycle start pulse with its operands. The arbiter latches the request and grants the adder round-robin. It drives the adder's start/operands and routes the adder result back with a one-cycle ready pulse. It sits between the evaluator's sub-controllers and a shared `add_*` port.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `DATA_WIDTH`, default 32: operand/result width (IEEE-754 single).
- `TIMEOUT_CYCLES`, default 64: watchdog limit. Used only when `FP_ADD_ARB_TIMEOUT_EN` is defined.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `req_start[NUM_REQ-1:0]`  in  1 each  one-cycle request pulse.
- `req_operand_a[NUM_REQ-1:0]`, `req_operand_b[NUM_REQ-1:0]`  in  DATA_WIDTH each  operands; sampled only on the `req_start` cycle.
- `req_result[NUM_REQ-1:0]`  out  DATA_WIDTH each  last sum for that requester.
- `req_result_ready[NUM_REQ-1:0]`  out  1 each  one-cycle result pulse.
- `req_overrun[NUM_REQ-1:0]`  out  1 each  sticky: request dropped.
- `add_operand_a`, `add_operand_b`  out  DATA_WIDTH  to the shared adder.
- `add_start`  out  1  one-cycle adder start.
- `add_result`  in  DATA_WIDTH  adder sum.
- `add_result_ready`  in  1  adder done pulse.
- `busy`  out  1  high when any request is pending or in flight.
- `timeout`  out  1  sticky watchdog flag.

## Operation
- Per requester: `pending[i]` bit plus latched `op_a[i]`, `op_b[i]`.
  - On `req_start[i]`: set pending and latch operands.
  - If already pending: set `req_overrun[i]`, drop the request, keep the old operands.
- The FSM has three states, `S_IDLE`, `S_ISSUE` and `S_WAIT`:
  - `S_IDLE`: if any bit of `pending` is set, grant the first pending index scanning from `last_grant+1` upward with wrap-around. Register `grant` and `last_grant <= grant`, then go to `S_ISSUE`.
  - `S_ISSUE`: `add_start=1` for this one cycle; go to `S_WAIT`.
  - `S_WAIT`: on `add_result_ready`:
    - latch `add_result` into `req_result[grant]`;
    - pulse `req_result_ready[grant]` the next cycle;
    - clear `pending[grant]`;
    - go to `S_IDLE`.
- `add_operand_a/b` equal `op_a/op_b[grant]` from `S_ISSUE` through `S_WAIT`. In `S_IDLE` they are 0.
- `add_result_ready` outside `S_WAIT` is ignored.
- A `req_start[grant]` on the same cycle as `add_result_ready` is a new request. It sets pending, is not an overrun, and latches the new operands.
- Simultaneous `req_start` from several requesters: all are latched and served in round-robin order.
- `busy` = any pending bit set, or FSM not in `S_IDLE`.

## Timing
- Reset values:
  - state `S_IDLE`;
  - `pending`, `req_overrun`, `req_result`, `req_result_ready`, `add_start`, `add_operand_a/b`, `timeout`, `busy` all 0;
  - `last_grant = NUM_REQ-1`, so requester 0 wins the first arbitration.
- Reset mid-operation discards all pending and in-flight work. A late `add_result_ready` after reset is ignored.
- Idle arbiter, `req_start[i]` in cycle 0: `add_start` high in cycle 2.
- `add_result_ready` in cycle n:
  - `req_result_ready[i]` high in cycle n+1, with `req_result[i]` valid from n+1;
  - `req_result[i]` is held until that requester's next result;
  - the next `add_start` comes no earlier than cycle n+3.
- Requester-to-requester fairness: with all requesters continuously pending, the grants cycle 0,1,..,NUM_REQ-1,0.

## Configuration
- `FP_ADD_ARB_TIMEOUT_EN` defined:
  - a counter runs in `S_WAIT`;
  - if `add_result_ready` has not arrived after `TIMEOUT_CYCLES` cycles in `S_WAIT`, set `timeout`, return `req_result[grant]=0` with a `req_result_ready` pulse, clear pending, and go to `S_IDLE`.
- Undefined: `S_WAIT` waits indefinitely, and `timeout` is tied to 0.

## Test plan
- Reset, then `req_start[1]` with a=0x3F800000, b=0x40000000. Expected: `add_start` in cycle 2 with those operands. Adder model returns 0x40400000 after 5 cycles. Expected: `req_result_ready[1]` pulses once and `req_result[1]`=0x40400000.
- `req_start[0..2]` in the same cycle. Expected: grants in order 0,1,2. Each result is routed to the correct index, and no `req_overrun` is set.
- Second `req_start[2]` while requester 2 is pending. Expected: `req_overrun[2]`=1, only one `add_start` for requester 2, original operands used.
- Requester 0 re-requests on the cycle its `add_result_ready` arrives while requester 1 is pending. Expected: requester 1 is served next, then requester 0 with the new operands, and no overrun.
- Assert `reset` during `S_WAIT`, then pulse `add_result_ready`. Expected: no `req_result_ready`, `busy`=0, `pending`=0.
- With `FP_ADD_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, the adder never responds. Expected: `timeout`=1, `req_result_ready[g]` pulses with `req_result[g]`=0, arbiter returns to `S_IDLE`.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that shares one floating-point adder between NUM_REQ requesters.
// Optional watchdog is enabled by defining FP_ADD_ARB_TIMEOUT_EN.
module fp_add_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_start,
  input  logic [DATA_WIDTH-1:0] req_operand_a [NUM_REQ-1:0],
  input  logic [DATA_WIDTH-1:0] req_operand_b [NUM_REQ-1:0],
  output logic [DATA_WIDTH-1:0] req_result [NUM_REQ-1:0],
  output logic [NUM_REQ-1:0]    req_result_ready,
  output logic [NUM_REQ-1:0]    req_overrun,
  output logic [DATA_WIDTH-1:0] add_operand_a,
  output logic [DATA_WIDTH-1:0] add_operand_b,
  output logic                  add_start,
  input  logic [DATA_WIDTH-1:0] add_result,
  input  logic                  add_result_ready,
  output logic                  busy,
  output logic                  timeout
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fp_add_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         cand;
  logic                  pick_valid;
  logic [NUM_REQ-1:0]    pending;
  logic [NUM_REQ-1:0]    clr;
  logic [DATA_WIDTH-1:0] op_a [NUM_REQ-1:0];
  logic [DATA_WIDTH-1:0] op_b [NUM_REQ-1:0];
  logic                  expire;
  logic                  done;

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((32'(last_grant) + off) % NUM_REQ);
      if (!pick_valid && pending[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  assign done = (state == S_WAIT) && (add_result_ready || expire);

  always_comb begin
    clr = '0;
    if (done) begin
      clr[grant] = 1'b1;
    end
  end

  // Arbitration is held off during the result pulse so the next add_start
  // trails the adder's done by at least three cycles.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (pick_valid && !(|req_result_ready)) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      grant            <= '0;
      last_grant       <= GW'(NUM_REQ - 1);
      req_result_ready <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_result[i] <= '0;
      end
    end else begin
      state            <= state_next;
      req_result_ready <= '0;
      if (state == S_IDLE && state_next == S_ISSUE) begin
        grant      <= pick;
        last_grant <= pick;
      end
      if (done) begin
        req_result[grant]       <= add_result_ready ? add_result : '0;
        req_result_ready[grant] <= 1'b1;
      end
    end
  end

  // A start on the completion cycle of the same requester is a fresh request.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending     <= '0;
      req_overrun <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_start[i]) begin
          if (pending[i] && !clr[i]) begin
            req_overrun[i] <= 1'b1;
          end else begin
            pending[i] <= 1'b1;
            op_a[i]    <= req_operand_a[i];
            op_b[i]    <= req_operand_b[i];
          end
        end else if (clr[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

`ifdef FP_ADD_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset || state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expire = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (done && !add_result_ready) begin
      timeout <= 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign add_start     = (state == S_ISSUE);
  assign add_operand_a = (state != S_IDLE) ? op_a[grant] : '0;
  assign add_operand_b = (state != S_IDLE) ? op_b[grant] : '0;
  assign busy          = (|pending) || (state != S_IDLE);

endmodule
